// File: rtl/spi_write_arbiter.sv
// Round-robin arbiter letting three register-write requesters share one SPI master.
// Latency: req sampled in IDLE -> spi_start next cycle; ack/err at earliest 3 cycles after spi_start.
// Backpressure: requesters hold req until ack/err; the SPI master paces via spi_busy, bounded by accept/done timeouts.
module spi_write_arbiter #(
    parameter int ACCEPT_TIMEOUT = 64,
    parameter int DONE_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [20:0] req_addr,
    input  logic [23:0] req_data,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic        spi_start,
    output logic [15:0] spi_datain,
    input  logic        spi_busy,
    output logic [1:0]  grant_id,
    output logic        arb_busy
);

    // One counter serves both wait states, so it is sized for the larger timeout.
    localparam int MAX_TO = (ACCEPT_TIMEOUT > DONE_TIMEOUT) ? ACCEPT_TIMEOUT : DONE_TIMEOUT;
    localparam int CW     = $clog2(MAX_TO + 1);
    localparam logic [CW-1:0] ACC_LIM  = CW'(ACCEPT_TIMEOUT);
    localparam logic [CW-1:0] DONE_LIM = CW'(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     last_q, last_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic           fail_q, fail_d;

    logic           win_vld;
    logic [1:0]     win_idx;
    logic [1:0]     cand;
    logic [6:0]     win_addr;
    logic [7:0]     win_data;
    logic [15:0]    word;

    // (base + ofs) mod 3 for base in 0..2, ofs in 1..3.
    function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] ofs);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Round-robin pick: scan last+1, last+2, last+3 (mod 3), first asserted req wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = rr_next(last_q, 2'(k));
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Route the winner's address/data to the latch inputs.
    always_comb begin
        case (win_idx)
            2'd1: begin
                win_addr = req_addr[13:7];
                win_data = req_data[15:8];
            end
            2'd2: begin
                win_addr = req_addr[20:14];
                win_data = req_data[23:16];
            end
            default: begin
                win_addr = req_addr[6:0];
                win_data = req_data[7:0];
            end
        endcase
    end

    assign cnt_inc = cnt_q + CW'(1);
    // Bit 15 is the SX1278 write flag; the word is frozen from grant until completion.
    assign word    = {1'b1, addr_q, data_q};

    // State and latched transaction registers; last grant resets to 2 so r0 is scanned first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd2;
            addr_q  <= 7'd0;
            data_q  <= 8'd0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        ack        = 3'b000;
        err        = 3'b000;
        spi_start  = 1'b0;
        spi_datain = 16'h0000;
        grant_id   = 2'd3;
        arb_busy   = 1'b1;

        if (state_q != S_IDLE) begin
            spi_datain = word;
            grant_id   = grant_q;
        end

        case (state_q)
            S_IDLE: begin
                arb_busy = 1'b0;
                cnt_d    = '0;
                if (win_vld) begin
                    grant_d = win_idx;
                    addr_d  = win_addr;
                    data_d  = win_data;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                spi_start = 1'b1;
                cnt_d     = '0;
                fail_d    = 1'b0;
                state_d   = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                // busy wins over timeout when both happen in the last allowed cycle
                if (spi_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ACC_LIM) begin
                        fail_d  = 1'b1;
                        state_d = S_COMPLETE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!spi_busy) begin
                    state_d = S_COMPLETE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DONE_LIM) begin
                        fail_d  = 1'b1;
                        state_d = S_COMPLETE;
                    end
                end
            end
            S_COMPLETE: begin
                if (fail_q) begin
                    err = 3'b001 << grant_q;
                end else begin
                    ack = 3'b001 << grant_q;
                end
                last_d  = grant_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Bench for spi_write_arbiter: transaction-level model predicts grants, words and completion cycles;
// a monitor compares every cycle's outputs against the predicted event stream.
// SPI master behaviour (accept delay, busy length) is chosen by the bench per transaction.
module tb_spi_write_arbiter;

    localparam int ACC_TO  = 64;
    localparam int DONE_TO = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [20:0] req_addr;
    logic [23:0] req_data;
    logic        spi_busy;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic        spi_start;
    logic [15:0] spi_datain;
    logic [1:0]  grant_id;
    logic        arb_busy;

    spi_write_arbiter #(
        .ACCEPT_TIMEOUT(ACC_TO),
        .DONE_TIMEOUT  (DONE_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .err       (err),
        .spi_start (spi_start),
        .spi_datain(spi_datain),
        .spi_busy  (spi_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         at;
        int         kind;   // 0 start, 1 ack, 2 err
        logic [1:0] id;
        logic [15:0] word;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // monitor view
    bit          mon_act = 1'b0;
    logic [1:0]  mon_id = 2'd0;
    logic [15:0] mon_word = 16'h0;
    logic [1:0]  dut_grants[$];
    int          start_cnt = 0, ack_cnt = 0, err_cnt = 0;
    int          last_start_cyc = 0, last_end_cyc = 0;
    logic [15:0] last_din = 16'h0;

    // reference model / stimulus state
    logic [1:0]  m_last = 2'd2;
    bit          m_act = 1'b0;
    logic [1:0]  m_id = 2'd0;
    int          m_done = 0, m_start = 0, idle_from = 0;
    int          busy_on = 0, busy_off = 0;
    bit          raise_en = 1'b0, scramble_en = 1'b0;
    int          keep_pct = 0;
    int          beh_da[$], beh_db[$];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic mon_cycle();
        ev_t         e;
        bit          fin = 1'b0;
        logic        es = 1'b0;
        logic [2:0]  ea = 3'b000, ee = 3'b000;
        logic [25:0] exp_v, act_v;
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            if (e.kind == 0) begin
                mon_act = 1'b1; mon_id = e.id; mon_word = e.word; es = 1'b1;
            end else if (e.kind == 1) begin
                ea = 3'b001 << e.id; fin = 1'b1;
            end else begin
                ee = 3'b001 << e.id; fin = 1'b1;
            end
        end
        exp_v = {es, ea, ee, mon_act, (mon_act ? mon_id : 2'd3), (mon_act ? mon_word : 16'h0000)};
        act_v = {spi_start, ack, err, arb_busy, grant_id, spi_datain};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle %0d: got start=%b ack=%b err=%b busy=%b gid=%0d din=%h, expected start=%b ack=%b err=%b busy=%b gid=%0d din=%h",
                     cyc, spi_start, ack, err, arb_busy, grant_id, spi_datain,
                     exp_v[25], exp_v[24:22], exp_v[21:19], exp_v[18], exp_v[17:16], exp_v[15:0]);
        end
        if (spi_start === 1'b1) begin
            dut_grants.push_back(grant_id);
            start_cnt++;
            last_start_cyc = cyc;
            last_din = spi_datain;
        end
        if (|ack === 1'b1) begin ack_cnt++; last_end_cyc = cyc; end
        if (|err === 1'b1) begin err_cnt++; last_end_cyc = cyc; end
        if (fin) mon_act = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) mon_cycle();
        end
    end

    // Grant by round-robin over the live request vector and predict the whole transaction.
    task automatic decide(input int c);
        int idx = -1;
        int da, db, s, done, kind, r;
        logic [6:0] a;
        logic [7:0] d;
        for (int k = 1; k <= 3; k++) begin
            int cidx = (int'(m_last) + k) % 3;
            if (idx < 0 && req[cidx]) idx = cidx;
        end
        a = req_addr[idx*7 +: 7];
        d = req_data[idx*8 +: 8];
        if (beh_da.size() > 0) begin
            da = beh_da.pop_front();
            db = beh_db.pop_front();
        end else begin
            r = $urandom_range(0, 9);
            if (r == 0) begin da = 1000; db = 0; end
            else if (r == 1) begin da = ACC_TO; db = $urandom_range(1, 4); end
            else begin da = $urandom_range(1, 6); db = $urandom_range(1, 20); end
        end
        s = c + 1;
        if (da > ACC_TO) begin
            busy_on = 0; busy_off = 0;
            done = s + ACC_TO + 1; kind = 2;
        end else begin
            busy_on = s + da; busy_off = s + da + db;
            if (db <= DONE_TO) begin done = s + da + db + 1; kind = 1; end
            else begin done = s + da + DONE_TO + 1; kind = 2; end
        end
        exp_q.push_back('{at: s, kind: 0, id: 2'(idx), word: {1'b1, a, d}});
        exp_q.push_back('{at: done, kind: kind, id: 2'(idx), word: {1'b1, a, d}});
        m_act = 1'b1; m_id = 2'(idx); m_done = done; m_start = s;
        m_last = 2'(idx); idle_from = done + 1;
    endtask

    task automatic drive_cycle();
        int c = cyc;
        if (m_act && c == m_done) begin
            m_act = 1'b0;
            if (int'($urandom_range(0, 99)) < keep_pct) begin
                req_addr[m_id*7 +: 7] = 7'($urandom);
                req_data[m_id*8 +: 8] = 8'($urandom);
            end else begin
                req[m_id] = 1'b0;
            end
        end else if (m_act && scramble_en && $urandom_range(0, 7) == 0) begin
            req_addr[m_id*7 +: 7] = 7'($urandom);
            req_data[m_id*8 +: 8] = 8'($urandom);
        end
        if (raise_en) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*7 +: 7] = 7'($urandom);
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
        end
        if (!rst && !m_act && c >= idle_from && req != 3'b000) decide(c);
        spi_busy = (c >= busy_on && c < busy_off);
    endtask

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        slot();
        drive_cycle();
    endtask

    // Call from a slot; holds rst for n edges and resumes the model in the first free IDLE cycle.
    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        mon_act = 1'b0;
        m_act = 1'b0;
        m_last = 2'd2;
        busy_on = 0; busy_off = 0;
        spi_busy = 1'b0;
        repeat (n) slot();
        rst = 1'b0;
        idle_from = cyc;
        drive_cycle();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m_act || req != 3'b000 || exp_q.size() > 0) && n < 6000) begin
            step();
            n++;
        end
        checks++;
        if (m_act || req != 3'b000 || exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s: idle wait expired after %0d cycles", tag, n);
        end
        step();
    endtask

    task automatic launch(input logic [2:0] r);
        slot();
        for (int i = 0; i < 3; i++) begin
            if (r[i]) begin
                req[i] = 1'b1;
                req_addr[i*7 +: 7] = 7'($urandom);
                req_data[i*8 +: 8] = 8'($urandom);
            end
        end
        drive_cycle();
    endtask

    initial begin
        int g0, a0, e0, s0, n;
        rst = 1'b1; req = 3'b000; req_addr = '0; req_data = '0; spi_busy = 1'b0;
        slot();
        mon_en = 1'b1;
        do_reset(3);
        repeat (3) step();

        // contention: all three held, each drops on its own ack -> 0,1,2
        g0 = dut_grants.size(); a0 = ack_cnt; s0 = start_cnt;
        launch(3'b111);
        wait_idle("contention");
        chk("contention_starts", start_cnt - s0, 3);
        chk("contention_acks", ack_cnt - a0, 3);
        for (int i = 0; i < 3; i++)
            chk("contention_order", (dut_grants.size() > g0 + i) ? int'(dut_grants[g0 + i]) : -1, i);

        // single write r0 addr 01 data 81, busy 1 cycle after start for 16 cycles
        a0 = ack_cnt; s0 = start_cnt; e0 = err_cnt;
        beh_da.push_back(1); beh_db.push_back(16);
        slot();
        req[0] = 1'b1; req_addr[6:0] = 7'h01; req_data[7:0] = 8'h81;
        drive_cycle();
        wait_idle("single");
        chk("single_starts", start_cnt - s0, 1);
        chk("single_acks", ack_cnt - a0, 1);
        chk("single_errs", err_cnt - e0, 0);
        chk("single_datain", int'(last_din), 16'h8181);
        chk("single_latency", last_end_cyc - last_start_cyc, 18);

        // round robin: r0 was last served, so r2 beats r0
        g0 = dut_grants.size();
        launch(3'b101);
        wait_idle("round_robin");
        chk("rr_first", (dut_grants.size() > g0) ? int'(dut_grants[g0]) : -1, 2);
        chk("rr_second", (dut_grants.size() > g0 + 1) ? int'(dut_grants[g0 + 1]) : -1, 0);

        // accept timeout: master never goes busy
        a0 = ack_cnt; e0 = err_cnt;
        beh_da.push_back(1000); beh_db.push_back(0);
        launch(3'b010);
        wait_idle("accept_timeout");
        chk("acc_to_errs", err_cnt - e0, 1);
        chk("acc_to_acks", ack_cnt - a0, 0);
        chk("acc_to_delay", last_end_cyc - last_start_cyc, ACC_TO + 1);

        // done timeout and the two boundaries that must still succeed
        e0 = err_cnt;
        beh_da.push_back(2); beh_db.push_back(DONE_TO + 1);
        launch(3'b001);
        wait_idle("done_timeout");
        chk("done_to_errs", err_cnt - e0, 1);
        chk("done_to_delay", last_end_cyc - last_start_cyc, 2 + DONE_TO + 1);
        a0 = ack_cnt;
        beh_da.push_back(3); beh_db.push_back(DONE_TO);
        launch(3'b100);
        wait_idle("done_edge");
        chk("done_edge_ack", ack_cnt - a0, 1);
        a0 = ack_cnt;
        beh_da.push_back(ACC_TO); beh_db.push_back(2);
        launch(3'b010);
        wait_idle("accept_edge");
        chk("accept_edge_ack", ack_cnt - a0, 1);
        chk("accept_edge_delay", last_end_cyc - last_start_cyc, ACC_TO + 3);

        // random traffic with re-requests and mid-transaction operand changes
        raise_en = 1'b1; keep_pct = 30; scramble_en = 1'b1;
        repeat (4000) step();
        raise_en = 1'b0; keep_pct = 0;
        wait_idle("random");
        scramble_en = 1'b0;

        // reset while in WAIT_DONE, then r0 must win
        a0 = ack_cnt; e0 = err_cnt;
        beh_da.push_back(1); beh_db.push_back(200);
        launch(3'b001);
        n = 0;
        while (!(m_act && cyc >= m_start + 5) && n < 100) begin step(); n++; end
        chk("reach_wait_done", int'(m_act && cyc >= m_start + 5), 1);
        slot();
        req = 3'b111;
        g0 = dut_grants.size();
        do_reset(2);
        chk("reset_no_pulse", (ack_cnt - a0) + (err_cnt - e0), 0);
        wait_idle("post_reset");
        chk("post_reset_first", (dut_grants.size() > g0) ? int'(dut_grants[g0]) : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
